pipe_stage_hs: RTL
==================

// Module: pipe_stage_hs
// PURPOSE
//  Generic inter-stage pipeline register with valid/ready handshake. Replaces the fixed per-stage latches
//  (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block.
//  Carries a control bundle and a data bundle, with flush-to-NOP semantics for the control bundle.
//  An optional 2-entry skid buffer registers the upstream ready, so stall is not a long combinational chain.
// PARAMETERS
//  CTRL_W   16     width of control bundle (RegWrite, MemRW, ALUControl, ...)
//  DATA_W   133    width of data bundle (PC, operands, imm, reg indices)
//  CTRL_NOP 0      control value presented on flush/reset; decode must map it to a no-op
//  SKID     1      1 = 2-entry skid, registered in_ready; 0 = single entry, combinational in_ready
// PORTS
//  CLK       in   1       clock, rising edge
//  RST       in   1       asynchronous reset, active-high
//  flush     in   1       kill all held and incoming beats this cycle
//  in_valid  in   1       upstream beat valid
//  in_ready  out  1       block can accept a beat this cycle
//  in_ctrl   in   CTRL_W  upstream control bundle
//  in_data   in   DATA_W  upstream data bundle
//  out_valid out  1       output beat valid
//  out_ready in   1       downstream accepts (0 = stall)
//  out_ctrl  out  CTRL_W  registered control; CTRL_NOP whenever out_valid=0
//  out_data  out  DATA_W  registered data; 0 whenever out_valid=0
//  occ       out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - Reset (async, RST=1): out_valid=0, out_ctrl=CTRL_NOP, out_data=0, occ=0, both entries empty.
//    in_ready=0 while RST=1 and 1 in the first cycle after release.
//  - Transfers: input fires on in_valid&in_ready at a rising edge; output fires on out_valid&out_ready.
//  - Latency: an accepted beat appears on out_* at the next edge. Throughput is 1 beat/cycle when out_ready=1.
//  - Hold: while out_valid&!out_ready, out_* are stable bit-for-bit. Order is strictly FIFO.
//  - SKID=1 FSM (main=M, skid=S):
//    EMPTY: in fires -> FULL (load M).
//    FULL:  in & out fire -> FULL (M<=in). Out only -> EMPTY. In only -> SKID (S<=in).
//    SKID:  out fires -> FULL (M<=S). Input cannot fire in this state.
//    in_ready = (state!=SKID), taken from a register and never from out_ready.
//  - SKID=0: single entry; in_ready = !out_valid | out_ready (combinational).
//  - Flush (synchronous, highest priority after RST): next state EMPTY, occ=0, out_valid=0, out_ctrl=CTRL_NOP, out_data=0.
//    A beat presented with in_valid in the flush cycle is dropped, even if in_ready=1.
//    An output fire in the same cycle still completes downstream.
//  - Bubble: out_valid=0 always implies out_ctrl=CTRL_NOP, so downstream may ignore out_valid for side effects.
//  - Reset mid-stream: all held beats are discarded immediately, with no glitch beat after release.
//  - occ reflects the post-edge state (EMPTY=0, FULL=1, SKID=2).
// TESTING
//  T1 Stream: SKID=1, out_ready=1, 8 beats data=1..8 back-to-back -> out_data 1..8 one cycle later; in_ready=1 throughout.
//  T2 Stall/skid: send A,B,C with out_ready=0 from cycle 1.
//     -> out holds A, occ=2, in_ready=0 after B. C is held upstream.
//     Raise out_ready: A, B, C emerge in order with no loss or duplication.
//  T3 Flush: occ=2 (A,B), flush=1 with in_valid=1 data=C.
//     -> next cycle out_valid=0, out_ctrl=CTRL_NOP, out_data=0, occ=0. C never appears.
//  T4 Reset mid-op: occ=2, pulse RST asynchronously mid-cycle.
//     -> outputs reset immediately, in_ready=0 during RST and 1 one cycle after release; no stale beat emerges.
//  T5 SKID=0: out_ready toggling 1,0,1,0 with continuous input.
//     -> in_ready equals !out_valid|out_ready each cycle; ordering preserved.
//  T6 Random: random in_valid/out_ready/flush (1%) vs scoreboard for 10k cycles.
//     -> no drop or reorder except by flush; out_* stable under stall.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised inter-stage pipeline register with valid/ready
// handshake, flush-to-NOP control, and an optional 2-entry skid buffer.
//
// Ports:
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   flush              drop every held and incoming beat this cycle
//   in_valid/in_ready  upstream handshake; in_ctrl/in_data upstream bundles
//   out_valid/out_ready downstream handshake; out_ctrl/out_data bundles
//   occ                entries held after the last edge (0..2)
module pipe_stage_hs #(
    parameter int                 CTRL_W   = 16,
    parameter int                 DATA_W   = 133,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 SKID     = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              rdy_q, rdy_d;
    logic              live_q;

    logic in_fire;
    logic out_fire;

    // Flush suppresses the input fire even when in_ready is high.
    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_NOP;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
            rdy_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
            live_q      <= 1'b1;
        end
    end

    // Next-state and datapath. The main entry is forced back to NOP/0
    // whenever it drains, so the outputs need no masking.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_NOP;
            main_data_d = '0;
            skid_ctrl_d = CTRL_NOP;
            skid_data_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = CTRL_NOP;
                        main_data_d = '0;
                    end else if (in_fire && SKID != 0) begin
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = CTRL_NOP;
                        skid_data_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = CTRL_NOP;
                    main_data_d = '0;
                    skid_ctrl_d = CTRL_NOP;
                    skid_data_d = '0;
                end
            endcase
        end
    end

    // Registered ready: only the post-edge state decides it, so the
    // downstream stall never reaches upstream combinationally.
    assign rdy_d = (state_d != ST_SKID);

    // Outputs
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_ctrl  = main_ctrl_q;
        out_data  = main_data_q;
        occ       = 2'd0;
        unique case (state_q)
            ST_FULL: occ = 2'd1;
            ST_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        if (SKID != 0) begin
            in_ready = rdy_q;
        end else begin
            in_ready = live_q & (~out_valid | out_ready);
        end
    end

endmodule
